seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexing scheduler that shares one 7-segment decoder across NUM_DIGITS common-anode digits of the chronometer display.
- Snapshots packed BCD digit values once per frame.
- Drives the shared decoder's 4-bit input, the active-low digit anodes and the decimal point.
- Inserts a dead-time gap between digits to suppress ghosting.
- Sits between the chronometer counters and the decoder / board pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; must be >= 2.
REFRESH_DIV, 50000, clock cycles per digit slot (drive + gap); must be > BLANK_CYCLES.
BLANK_CYCLES, 16, cycles per slot with all anodes off; must be >= 1.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  scan enable; 0 forces display dark.
digits_in  input  4*NUM_DIGITS  packed digit codes; nibble i = digit i; digit 0 least significant.
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
blank_in  input  NUM_DIGITS  per-digit blank request, active-high.
dec_code  output  4  code to the shared 7-seg decoder; 4'hF = blank.
anode_n  output  NUM_DIGITS  digit select, active-low, at most one bit low.
dp_n  output  1  decimal point, active-low.
frame_start  output  1  one-cycle pulse when a new snapshot is loaded.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (async, rst_n=0):
  - state=IDLE, idx=0, slot counter=0, snapshot registers=0.
  - anode_n=all 1, dec_code=4'hF, dp_n=1, frame_start=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: display dark. If en=1 at an edge, go to DRIVE with idx=0, snapshot captured, frame_start=1, counter=0.
  - DRIVE: anode_n[idx]=0, dec_code=snap_digit[idx], dp_n=~snap_dp[idx]. Lasts REFRESH_DIV-BLANK_CYCLES cycles, then go to GAP with counter reset.
  - GAP: anode_n=all 1, dp_n=1, dec_code=4'hF. Lasts BLANK_CYCLES cycles, then go to DRIVE with idx+1.
- Wrap-around: when idx=NUM_DIGITS-1, leaving GAP wraps idx to 0, reloads the snapshot (digits_in, dp_in, blank_in) and pulses frame_start in that same cycle.
- Snapshot: inputs are sampled only on snapshot cycles. Changes mid-frame do not appear until the next frame (no tearing).
- Blanked digit (snap_blank[idx]=1): DRIVE slot keeps anode_n=all 1, dp_n=1, dec_code=4'hF. Slot timing is unchanged.
- Codes 4'hA–4'hF pass through unmodified; the decoder handles them.
- en falling:
  - The next edge enters IDLE from any state and outputs go dark on that edge.
  - idx and counter reset to 0.
  - A later en=1 restarts a full frame at digit 0.
- Reset asserted mid-slot: immediate dark outputs, with no partial-slot completion.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. frame_start period is exactly that while en=1.

Optional Feature:
SEG_SCAN_LZB_EN
- Defined: leading-zero blanking is evaluated on each snapshot. Digits above the highest non-zero digit with code 4'h0 are treated as blanked. Digit 0 is never blanked by this rule. The result is ORed with blank_in.
- Undefined: only blank_in blanks digits. Zeros display normally.

Decomposition:
- Package seg_scan_pkg:
  - state enum {IDLE, DRIVE, GAP}.
  - DEC_BLANK=4'hF.
  - Width helper constant for the slot counter (clog2 of REFRESH_DIV).
- Sub-module scan_slot_timer: slot counter with load/terminal-count outputs for the drive and gap lengths.
- Snapshot, idx and FSM stay in the top module.

Test Plan:
- Reset then en=1, digits_in=16'h1234, NUM_DIGITS=4, REFRESH_DIV=20, BLANK_CYCLES=4 -> slots are 16 cycles DRIVE + 4 GAP. Order is anode_n=1110/code 4 → 1101/3 → 1011/2 → 0111/1, then repeat. frame_start pulses every 80 cycles.
- Change digits_in to 16'h5678 mid-frame -> current frame still shows 1234. Next frame, after frame_start, shows 8,7,6,5.
- blank_in=4'b0100, dp_in=4'b0010 -> digit 2 slot has anode_n=1111 and code F. dp_n=0 only during the digit 1 DRIVE slot.
- en deasserted during DRIVE of digit 2 -> next edge gives anode_n=1111, dec_code=F. Re-enable restarts at digit 0 with frame_start.
- Assert rst_n=0 asynchronously mid-GAP -> outputs return to reset values without waiting for a clock edge.
- With SEG_SCAN_LZB_EN, digits_in=16'h0070 -> digits 3 and 2 dark, digit 1 shows 7, digit 0 shows 0. digits_in=16'h0000 -> only digit 0 lit, showing 0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } scan_state_e;

  localparam logic [3:0] DEC_BLANK = 4'hF;

  // Slot counter width; never narrower than one bit.
  function automatic int slot_cnt_width(input int refresh_div);
    if (refresh_div <= 2) begin
      return 1;
    end else begin
      return $clog2(refresh_div);
    end
  endfunction

  localparam int SLOT_CNT_W_DEFAULT = slot_cnt_width(50000);

endpackage

// File: rtl/scan_slot_timer.sv
// Per-slot cycle counter with terminal-count flags for the drive and gap phases.
module scan_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic drive_tc,
  output logic gap_tc
);

  localparam int CNT_W     = slot_cnt_width(REFRESH_DIV);
  localparam int DRIVE_LEN = REFRESH_DIV - BLANK_CYCLES;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign drive_tc = (cnt_q == CNT_W'(DRIVE_LEN - 1));
  assign gap_tc   = (cnt_q == CNT_W'(BLANK_CYCLES - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared decoder.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [3:0]              dec_code,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_digit_q, snap_digit_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
  logic [3:0]              dec_code_q, dec_code_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_start_q, frame_start_d;

  logic                    load_s;
  logic                    timer_clr_s;
  logic                    timer_run_s;
  logic                    drive_tc_s;
  logic                    gap_tc_s;
  logic [NUM_DIGITS-1:0]   lzb_mask_s;

  scan_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr_s),
    .run      (timer_run_s),
    .drive_tc (drive_tc_s),
    .gap_tc   (gap_tc_s)
  );

  // Digits above the highest non-zero digit that read zero; digit 0 never qualifies.
  always_comb begin
    lzb_mask_s = '0;
`ifdef SEG_SCAN_LZB_EN
    begin : g_lzb
      logic zero_run;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        zero_run      = zero_run & (digits_in[4*i +: 4] == 4'h0);
        lzb_mask_s[i] = zero_run;
      end
    end
`else
    lzb_mask_s = '0;
`endif
  end

  // Scan FSM, digit index and frame snapshot.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    load_s        = 1'b0;
    timer_clr_s   = 1'b0;
    timer_run_s   = 1'b0;
    frame_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_clr_s = 1'b1;
        idx_d       = '0;
        if (en) begin
          state_d       = DRIVE;
          load_s        = 1'b1;
          frame_start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (!en) begin
          state_d     = IDLE;
          idx_d       = '0;
          timer_clr_s = 1'b1;
        end else if (drive_tc_s) begin
          state_d     = GAP;
          timer_clr_s = 1'b1;
        end else begin
          timer_run_s = 1'b1;
        end
      end
      GAP: begin
        if (!en) begin
          state_d     = IDLE;
          idx_d       = '0;
          timer_clr_s = 1'b1;
        end else if (gap_tc_s) begin
          state_d     = DRIVE;
          timer_clr_s = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d         = '0;
            load_s        = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          timer_run_s = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        idx_d       = '0;
        timer_clr_s = 1'b1;
      end
    endcase

    if (load_s) begin
      snap_digit_d = digits_in;
      snap_dp_d    = dp_in;
      snap_blank_d = blank_in | lzb_mask_s;
    end else begin
      snap_digit_d = snap_digit_q;
      snap_dp_d    = snap_dp_q;
      snap_blank_d = snap_blank_q;
    end
  end

  // Outputs follow the next state so they change on the same edge as the FSM.
  always_comb begin
    anode_n_d  = '1;
    dec_code_d = DEC_BLANK;
    dp_n_d     = 1'b1;
    if (state_d == DRIVE && !snap_blank_d[idx_d]) begin
      anode_n_d  = ~(NUM_DIGITS'(1) << idx_d);
      dec_code_d = snap_digit_d[4*int'(idx_d) +: 4];
      dp_n_d     = ~snap_dp_d[idx_d];
    end else begin
      anode_n_d  = '1;
      dec_code_d = DEC_BLANK;
      dp_n_d     = 1'b1;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      snap_digit_q  <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      anode_n_q     <= '1;
      dec_code_q    <= DEC_BLANK;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_digit_q  <= snap_digit_d;
      snap_dp_q     <= snap_dp_d;
      snap_blank_q  <= snap_blank_d;
      anode_n_q     <= anode_n_d;
      dec_code_q    <= dec_code_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode_n     = anode_n_q;
  assign dec_code    = dec_code_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected frames are queued by the stimulus, a monitor checks each frame.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 20;
  localparam int BC = 4;
  localparam int DL = RD - BC;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [15:0]   digits_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic [3:0]    dec_code;
  logic [3:0]    anode_n;
  logic          dp_n;
  logic          frame_start;

  typedef struct packed {
    logic [15:0] codes;  // nibble s = expected dec_code during slot s drive
    logic [15:0] ans;    // nibble s = expected anode_n during slot s drive
    logic [3:0]  dpn;    // bit s = expected dp_n during slot s drive
    logic [7:0]  len;    // cycles of this frame to check
  } frame_t;

  frame_t exp_q[$];
  int     chk_cnt  = 0;
  int     pass_cnt = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .dec_code    (dec_code),
    .anode_n     (anode_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got {fs,dp_n,anode_n,code}=%b_%b_%b_%h, want %b_%b_%b_%h at %0t",
               name, act[9], act[8], act[7:4], act[3:0], exp[9], exp[8], exp[7:4], exp[3:0], $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {frame_start, dp_n, anode_n, dec_code};
  endfunction

  localparam logic [9:0] DARK = {1'b0, 1'b1, 4'b1111, 4'hF};

  task automatic push_frame(input logic [15:0] codes, input logic [15:0] ans,
                            input logic [3:0] dpn, input int len);
    frame_t f;
    f.codes = codes;
    f.ans   = ans;
    f.dpn   = dpn;
    f.len   = 8'(len);
    exp_q.push_back(f);
  endtask

  // Monitor: each frame_start pops one expected frame and checks it cycle by cycle.
  initial begin
    frame_t f;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && frame_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_start", outs(), DARK);
        end else begin
          f = exp_q.pop_front();
          for (int c = 0; c < int'(f.len); c++) begin
            int s;
            int p;
            if (c > 0) @(negedge clk);
            s = c / RD;
            p = c % RD;
            if (p < DL) begin
              e = {(c == 0), f.dpn[s], f.ans[4*s +: 4], f.codes[4*s +: 4]};
            end else begin
              e = DARK;
            end
            chk($sformatf("frame_slot%0d_cyc%0d", s, p), outs(), e);
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    en        = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    blank_in  = 4'b0000;
    #1 rst_n  = 1'b0;
    #3;
    chk("reset_values", outs(), DARK);
    repeat (2) @(negedge clk);
    chk("reset_held", outs(), DARK);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_en_low", outs(), DARK);

    // Frame 1 shows 1234; digits change mid-frame and appear only in frame 2.
    push_frame(16'h1234, 16'h7BDE, 4'b1111, 80);
    en = 1'b1;
    repeat (30) @(negedge clk);
    digits_in = 16'h5678;
    push_frame(16'h5678, 16'h7BDE, 4'b1111, 80);
    repeat (80) @(negedge clk);
    blank_in = 4'b0100;
    dp_in    = 4'b0010;
    push_frame(16'h5F78, 16'h7FDE, 4'b1101, 80);
    repeat (80) @(negedge clk);
    blank_in = 4'b0000;
    dp_in    = 4'b0000;
    // Frame 4 is cut short by en falling during digit 2 drive.
    push_frame(16'h5678, 16'h7BDE, 4'b1111, 45);
    repeat (95) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_fall_dark", outs(), DARK);
    repeat (3) @(negedge clk);
    chk("en_low_idle", outs(), DARK);

    // Restart at digit 0, then reset asynchronously mid-drive.
    push_frame(16'h5678, 16'h7BDE, 4'b1111, 6);
    en = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_mid_drive", outs(), DARK);

    @(negedge clk);
    chk("reset_low_dark", outs(), DARK);
    digits_in = 16'hBA90;
    push_frame(16'hBA90, 16'h7BDE, 4'b1111, 80);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    digits_in = 16'h0070;
`ifdef SEG_SCAN_LZB_EN
    push_frame(16'hFF70, 16'hFFDE, 4'b1111, 80);
`else
    push_frame(16'h0070, 16'h7BDE, 4'b1111, 80);
`endif
    repeat (80) @(negedge clk);
    digits_in = 16'h0000;
`ifdef SEG_SCAN_LZB_EN
    push_frame(16'hFFF0, 16'hFFFE, 4'b1111, 80);
`else
    push_frame(16'h0000, 16'h7BDE, 4'b1111, 80);
`endif
    repeat (130) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("final_dark", outs(), DARK);
    chk_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL frames_left: got %0d pending frames, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
